cp0_exc_ctrl: RTL and testbench

//  Parametrised CP0 register file and exception controller for the MEM-stage commit point.

---
 rtl/cp0_exc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file and MEM-stage exception controller with Count/Compare timer.
// Optional CP0_BADVADDR_EN adds BadVAddr (reg 8), badvaddr_i and the AdES request bit.
module cp0_exc_ctrl #(
  parameter int          NUM_HW_INT = 6,
  parameter int          TIMER_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] PRID_VAL   = 32'h0000_4802
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           rdata_o,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic                  commit_valid_i,
`ifdef CP0_BADVADDR_EN
  input  logic [6:0]            exc_req_i,
  input  logic [31:0]           badvaddr_i,
`else
  input  logic [5:0]            exc_req_i,
`endif
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_delayslot_i,
  output logic                  flush_o,
  output logic [31:0]           new_pc_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  timer_int_o
);

  logic [31:0] count_q, compare_q, status_q, epc_q, presc_q;
  logic [4:0]  excode_q;
  logic [1:0]  ip_sw_q;
  logic        bd_q, timer_q;
`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q;
`endif

  // Hardware IP lines are sampled live; lines beyond NUM_HW_INT read 0.
  logic [5:0] hw_line;
  for (genvar g = 0; g < 6; g++) begin : g_hw
    if (g < NUM_HW_INT) begin : g_on
      assign hw_line[g] = int_i[g];
    end else begin : g_off
      assign hw_line[g] = 1'b0;
    end
  end

  logic [7:0] ip;
  assign ip = {hw_line[5] | timer_q, hw_line[4:0], ip_sw_q};

  logic [31:0] cause_val;
  assign cause_val = {bd_q, 15'b0, ip, 1'b0, excode_q, 2'b00};

  logic int_pend, exc_take, eret_take, flush_core, wr;
  logic [4:0] code;
  assign int_pend = status_q[0] & ~status_q[1] & |(ip[7:2] & status_q[15:10]);

  always_comb begin
    exc_take  = 1'b0;
    eret_take = 1'b0;
    code      = 5'd0;
    if (commit_valid_i) begin
      exc_take = 1'b1;
      if (int_pend)          code = 5'd0;
      else if (exc_req_i[0]) code = 5'd4;
      else if (exc_req_i[1]) code = 5'd10;
      else if (exc_req_i[2]) code = 5'd8;
      else if (exc_req_i[3]) code = 5'd13;
      else if (exc_req_i[4]) code = 5'd12;
`ifdef CP0_BADVADDR_EN
      else if (exc_req_i[6]) code = 5'd5;
`endif
      else begin
        exc_take  = 1'b0;
        eret_take = exc_req_i[5];
      end
    end
  end

  assign flush_core = exc_take | eret_take;
  assign wr         = we_i & ~flush_core;
  assign flush_o    = ~rst & flush_core;
  assign new_pc_o   = rst ? 32'h0 : exc_take ? EXC_VECTOR : eret_take ? epc_q : 32'h0;

  // Forwarded MTC0 data only exposes what the write would actually store.
  logic        fwd;
  logic [31:0] fwd_mask, reg_val;
  always_comb begin
    fwd_mask = 32'h0;
    reg_val  = 32'h0;
    case (raddr_i)
      5'd9:  begin reg_val = count_q;   fwd_mask = 32'hFFFF_FFFF; end
      5'd11: begin reg_val = compare_q; fwd_mask = 32'hFFFF_FFFF; end
      5'd12: begin reg_val = status_q;  fwd_mask = 32'hFFFF_FFFF; end
      5'd13: begin reg_val = cause_val; fwd_mask = 32'h0000_0300; end
      5'd14: begin reg_val = epc_q;     fwd_mask = 32'hFFFF_FFFF; end
      5'd15: reg_val = PRID_VAL;
`ifdef CP0_BADVADDR_EN
      5'd8:  reg_val = badvaddr_q;
`endif
      default: reg_val = 32'h0;
    endcase
  end
  assign fwd     = we_i & (waddr_i == raddr_i) & (fwd_mask != 32'h0);
  assign rdata_o = rst ? 32'h0 : fwd ? (wdata_i & fwd_mask) : reg_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      status_q  <= 32'h1000_0000;
      epc_q     <= 32'h0;
      presc_q   <= 32'h0;
      excode_q  <= 5'd0;
      ip_sw_q   <= 2'b00;
      bd_q      <= 1'b0;
      timer_q   <= 1'b0;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= 32'h0;
`endif
    end else begin
      if (wr && waddr_i == 5'd9) begin
        count_q <= wdata_i;
        presc_q <= 32'h0;
      end else if (presc_q == 32'(TIMER_DIV - 1)) begin
        count_q <= count_q + 32'd1;
        presc_q <= 32'h0;
      end else begin
        presc_q <= presc_q + 32'd1;
      end

      if (wr && waddr_i == 5'd11) begin
        compare_q <= wdata_i;
        timer_q   <= 1'b0;
      end else if (count_q == compare_q && compare_q != 32'h0) begin
        timer_q <= 1'b1;
      end

      if (wr && waddr_i == 5'd12) status_q <= wdata_i;
      if (wr && waddr_i == 5'd13) ip_sw_q  <= wdata_i[9:8];
      if (wr && waddr_i == 5'd14) epc_q    <= wdata_i;

      if (exc_take) begin
        excode_q    <= code;
        status_q[1] <= 1'b1;
        if (!status_q[1]) begin
          epc_q <= exc_pc_i - (exc_delayslot_i ? 32'd4 : 32'd0);
          bd_q  <= exc_delayslot_i;
        end
`ifdef CP0_BADVADDR_EN
        if (code == 5'd4 || code == 5'd5) badvaddr_q <= badvaddr_i;
`endif
      end else if (eret_take) begin
        status_q[1] <= 1'b0;
      end
    end
  end

  assign status_o    = status_q;
  assign cause_o     = cause_val;
  assign epc_o       = epc_q;
  assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: MTC0/MFC0 vector table plus timer and exception sequences.
module tb_cp0_exc_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] wdata_i, rdata_o;
  logic [5:0]  int_i;
  logic        commit_valid_i;
`ifdef CP0_BADVADDR_EN
  logic [6:0]  exc_req_i;
  logic [31:0] badvaddr_i;
`else
  logic [5:0]  exc_req_i;
`endif
  logic [31:0] exc_pc_i;
  logic        exc_delayslot_i;
  logic        flush_o;
  logic [31:0] new_pc_o, status_o, cause_o, epc_o;
  logic        timer_int_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .int_i(int_i), .commit_valid_i(commit_valid_i),
    .exc_req_i(exc_req_i),
`ifdef CP0_BADVADDR_EN
    .badvaddr_i(badvaddr_i),
`endif
    .exc_pc_i(exc_pc_i), .exc_delayslot_i(exc_delayslot_i), .flush_o(flush_o),
    .new_pc_o(new_pc_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .timer_int_o(timer_int_o)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'h0;
    commit_valid_i = 1'b0; exc_req_i = '0; exc_pc_i = 32'h0; exc_delayslot_i = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    step();
    we_i = 1'b0;
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b1, 5'd12, 32'h0000FF01, 5'd12, 32'h0000FF01};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd12, 32'h0000FF01};
    tbl[2] = '{1'b1, 5'd14, 32'h00001234, 5'd14, 32'h00001234};
    tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd14, 32'h00001234};
    tbl[4] = '{1'b1, 5'd13, 32'hFFFFFFFF, 5'd13, 32'h00000300};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd13, 32'h00000300};
    tbl[6] = '{1'b1, 5'd13, 32'h00000000, 5'd13, 32'h00000000};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd15, 32'h00004802};
    tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd8,  32'h00000000};
    tbl[9] = '{1'b1, 5'd12, 32'h10000000, 5'd3,  32'h00000000};

    rst = 1'b1; int_i = '0; raddr_i = 5'd15;
`ifdef CP0_BADVADDR_EN
    badvaddr_i = 32'h0;
`endif
    idle();
    step(); step();
    #1;
    check("rst_flush", {31'b0, flush_o}, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_newpc", new_pc_o, 32'h0);
    check("rst_timer", {31'b0, timer_int_o}, 32'h0);
    step();
    rst = 1'b0;
    raddr_i = 5'd12; #1 check("rst_status", rdata_o, 32'h10000000);
    raddr_i = 5'd13; #1 check("rst_cause", rdata_o, 32'h0);
    raddr_i = 5'd14; #1 check("rst_epc", rdata_o, 32'h0);
    raddr_i = 5'd15; #1 check("rst_prid", rdata_o, 32'h00004802);
    check("rst_flush2", {31'b0, flush_o}, 32'h0);
    step();

    for (int i = 0; i < 10; i++) begin
      we_i = tbl[i].we; waddr_i = tbl[i].waddr; wdata_i = tbl[i].wdata; raddr_i = tbl[i].raddr;
      #1;
      check($sformatf("vec%0d", i), rdata_o, tbl[i].exp);
      step();
    end
    idle();

    // Timer: Count=0, then Compare=5; match at Count=5 registers on the following edge.
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd5);
    n = 1;
    while (!timer_int_o && n < 30) begin
      step();
      n++;
    end
    check("timer_latency", n, 32'd11);
    raddr_i = 5'd13; #1;
    check("timer_cause15", {31'b0, rdata_o[15]}, 32'h1);
    // Count is still 5 here, so this Compare write collides with a live match.
    mtc0(5'd11, 32'h0);
    check("timer_clr", {31'b0, timer_int_o}, 32'h0);
    step();
    check("timer_clr2", {31'b0, timer_int_o}, 32'h0);

    // Count write on an increment edge wins and restarts the prescaler.
    mtc0(5'd9, 32'h0);
    step();
    raddr_i = 5'd9;
    mtc0(5'd9, 32'h100);
    check("cnt_wr_wins", rdata_o, 32'h100);
    step();
    check("cnt_presc0", rdata_o, 32'h100);
    step();
    check("cnt_inc", rdata_o, 32'h101);

    // Interrupt in a delay slot.
    mtc0(5'd12, 32'h0000FF01);
    int_i = 6'b000001; commit_valid_i = 1'b1; exc_pc_i = 32'h100; exc_delayslot_i = 1'b1;
    #1;
    check("int_flush", {31'b0, flush_o}, 32'h1);
    check("int_newpc", new_pc_o, 32'h40);
    step();
    check("int_epc", epc_o, 32'hFC);
    check("int_cause", cause_o, 32'h80000400);
    check("int_status", status_o, 32'h0000FF03);
    int_i = '0; idle();

    // Priority: ov+syscall+ri -> RI.
    mtc0(5'd12, 32'h0000FF00);
    commit_valid_i = 1'b1; exc_req_i = 6'b010110; exc_pc_i = 32'h200;
    #1 check("ri_newpc", new_pc_o, 32'h40);
    step();
    check("ri_cause", cause_o, 32'h00000028);
    check("ri_epc", epc_o, 32'h200);
    check("ri_status", status_o, 32'h0000FF02);

    // Nested syscall: EPC held.
    exc_req_i = 6'b000100; exc_pc_i = 32'h300;
    #1 check("sys_flush", {31'b0, flush_o}, 32'h1);
    step();
    check("sys_epc", epc_o, 32'h200);
    check("sys_cause", cause_o, 32'h00000020);

    // eret with a colliding MTC0 EPC.
    exc_req_i = 6'b100000; exc_pc_i = 32'h304;
    we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h300;
    #1;
    check("eret_flush", {31'b0, flush_o}, 32'h1);
    check("eret_newpc", new_pc_o, 32'h200);
    step();
    check("eret_status", status_o, 32'h0000FF00);
    check("eret_epc", epc_o, 32'h200);
    idle();

    // Requests ignored without commit.
    exc_req_i = 6'b000001;
    #1 check("nocommit", {31'b0, flush_o}, 32'h0);
    step();
    check("nocommit_st", status_o, 32'h0000FF00);

    // AdEL beats RI.
    commit_valid_i = 1'b1; exc_req_i = 6'b000011; exc_pc_i = 32'h400;
    step();
    check("adel_cause", cause_o, 32'h00000010);
    check("adel_epc", epc_o, 32'h400);
    idle();

    // Reset in the middle of an exception.
    rst = 1'b1; commit_valid_i = 1'b1; exc_req_i = 6'b000001; exc_pc_i = 32'h500;
    #1 check("rstexc_flush", {31'b0, flush_o}, 32'h0);
    step();
    check("rstexc_status", status_o, 32'h10000000);
    check("rstexc_epc", epc_o, 32'h0);
    check("rstexc_cause", cause_o, 32'h0);
    idle();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
